mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_if.sv | 24 ++
 rtl/mdu.sv | 114 +++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Bus between a requester and the multiply/divide unit.
// The requester drives the operation and operands; the MDU returns busy, HI and LO.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             req;
  logic [3:0]       MDUop;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, req, MDUop, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, req, MDUop, A, B,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Operands are latched at accept; the result lands in HI/LO on the edge where busy falls.
module mdu #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int unsigned MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW     = (MAXLAT < 2) ? 1 : $clog2(MAXLAT);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } op_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             sgn_q, busy_q;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b, mag_q, mag_r, quo, rem;
  logic               done, accept;

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  // Signed results are derived from unsigned magnitudes: quotient truncates
  // toward zero and the remainder takes the dividend's sign.
  always_comb begin
    ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    prod  = ext_a * ext_b;
    neg_a = sgn_q & a_q[WIDTH-1];
    neg_b = sgn_q & b_q[WIDTH-1];
    mag_a = neg_a ? ('0 - a_q) : a_q;
    mag_b = neg_b ? ('0 - b_q) : b_q;
    mag_q = mag_a / mag_b;
    mag_r = mag_a % mag_b;
    quo   = (neg_a ^ neg_b) ? ('0 - mag_q) : mag_q;
    rem   = neg_a ? ('0 - mag_r) : mag_r;
  end

  always_comb begin
    done   = (state_q != IDLE) && (cnt_q == '0);
    accept = bus.start && !bus.req && ((state_q == IDLE) || done) &&
             (bus.MDUop >= 4'd1) && (bus.MDUop <= 4'd6);
  end

  // A new operation may be accepted on the completion edge; its writes are
  // placed after the completion writes so an mthi/mtlo there takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (done) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        if (state_q == MUL) begin
          hi_q <= prod[2*WIDTH-1:WIDTH];
          lo_q <= prod[WIDTH-1:0];
        end else if (b_q != '0) begin
          hi_q <= rem;
          lo_q <= quo;
        end
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (accept) begin
        case (op_e'(bus.MDUop))
          OP_MULT, OP_MULTU: begin
            state_q <= MUL;
            cnt_q   <= CW'(MULT_LAT - 1);
            busy_q  <= 1'b1;
            a_q     <= bus.A;
            b_q     <= bus.B;
            sgn_q   <= (bus.MDUop == OP_MULT);
          end
          OP_DIV, OP_DIVU: begin
            state_q <= DIV;
            cnt_q   <= CW'(DIV_LAT - 1);
            busy_q  <= 1'b1;
            a_q     <= bus.A;
            b_q     <= bus.B;
            sgn_q   <= (bus.MDUop == OP_DIV);
          end
          OP_MTHI: hi_q <= bus.A;
          OP_MTLO: lo_q <= bus.A;
          default: ;
        endcase
      end
    end
  end
endmodule
